mmio_interconnect: RTL and testbench

MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_decoder.sv | 30 +++
 rtl/mmio_interconnect.sv | 170 +++++++++++++++++
 tb/tb_mmio_interconnect.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO interconnect: FSM encoding and default constants.
package mmio_pkg;

  localparam int unsigned DEF_DEC_BITS = 4;
  localparam int unsigned DEF_TIMEOUT  = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mmio_decoder.sv
// Address decoder: maps the decoded address MSBs to a slave index, lowest index wins.
module mmio_decoder
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 9,
  parameter int unsigned DEC_BITS   = DEF_DEC_BITS,
  parameter int unsigned IDX_W      = 4,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_MASK = '0
) (
  input  logic [DEC_BITS-1:0] addr_msb,
  output logic                match,
  output logic [IDX_W-1:0]    idx
);

  // Priority match scan; the first hit found locks out higher indices.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!match &&
          ((addr_msb & SLAVE_MASK[i*DEC_BITS +: DEC_BITS]) ==
           (SLAVE_BASE[i*DEC_BITS +: DEC_BITS] & SLAVE_MASK[i*DEC_BITS +: DEC_BITS]))) begin
        match = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mmio_interconnect.sv
// Single-master MMIO interconnect: decodes, forwards one access at a time, times out stalled slaves.
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEC_BITS   = DEF_DEC_BITS,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] SLAVE_MASK = '0,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic [31:0]                  m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [31:0]                  err_addr
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [STRB_W-1:0]    strb_q, strb_d;
  logic [31:0]          addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic [NUM_SLAVES-1:0] s_req_d;
  logic [STRB_W-1:0]    s_wstrb_d;
  logic                 m_ready_d;
  logic                 m_err_d;
  logic [DATA_W-1:0]    m_rdata_d;
  logic [31:0]          err_addr_d;

  logic                 dec_match;
  logic [IDX_W-1:0]     dec_idx;
  logic                 sel_ready;
  logic [DATA_W-1:0]    sel_rdata;

  mmio_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .DEC_BITS   (DEC_BITS),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr_msb (m_addr[31:32-DEC_BITS]),
    .match    (dec_match),
    .idx      (dec_idx)
  );

  // Pick the ready/rdata of the selected slave only; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic; slave-side strobes/selects only live in ACCESS.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    strb_d     = strb_q;
    addr_d     = s_addr;
    wdata_d    = s_wdata;
    s_req_d    = '0;
    s_wstrb_d  = '0;
    m_ready_d  = 1'b0;
    m_err_d    = 1'b0;
    m_rdata_d  = m_rdata;
    err_addr_d = err_addr;

    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          strb_d  = m_wstrb;
          if (dec_match) begin
            idx_d     = dec_idx;
            cnt_d     = '0;
            state_d   = ST_ACCESS;
            s_req_d   = NUM_SLAVES'(1) << dec_idx;
            s_wstrb_d = m_wstrb;
          end else begin
            state_d    = ST_RESP;
            m_ready_d  = 1'b1;
            m_err_d    = 1'b1;
            m_rdata_d  = '0;
            err_addr_d = m_addr;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          m_rdata_d = sel_rdata;
        end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = ST_RESP;
          m_ready_d  = 1'b1;
          m_err_d    = 1'b1;
          m_rdata_d  = '0;
          err_addr_d = s_addr;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          s_req_d   = NUM_SLAVES'(1) << idx_q;
          s_wstrb_d = strb_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      strb_q   <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_req    <= '0;
      s_wstrb  <= '0;
      m_ready  <= 1'b0;
      m_err    <= 1'b0;
      m_rdata  <= '0;
      err_addr <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      strb_q   <= strb_d;
      s_addr   <= addr_d;
      s_wdata  <= wdata_d;
      s_req    <= s_req_d;
      s_wstrb  <= s_wstrb_d;
      m_ready  <= m_ready_d;
      m_err    <= m_err_d;
      m_rdata  <= m_rdata_d;
      err_addr <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed bench for mmio_interconnect with a small 4-slave map and TIMEOUT=4.
module tb_mmio_interconnect;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DB = 4;
  // slave3=0101/F, slave2=1100/F, slave1=1xxx, slave0=0000/F
  localparam logic [NS*DB-1:0] BASE = {4'b0101, 4'b1100, 4'b1000, 4'b0000};
  localparam logic [NS*DB-1:0] MASK = {4'b1111, 4'b1111, 4'b1000, 4'b1111};
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_1111;
  localparam logic [31:0] D2 = 32'hC2C2_2222;
  localparam logic [31:0] D3 = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic [31:0]     m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  logic [NS-1:0]   s_req;
  logic [31:0]     s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [NS-1:0]   s_ready;
  logic [NS*DW-1:0] s_rdata;
  logic [31:0]     err_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int          acc_cnt = 0;
  int          ready_at = 99;
  logic [NS-1:0] stray = '0;

  int          obs_lat;
  logic        obs_done;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [NS-1:0] obs_req;
  logic [NS-1:0] req_at_rdy;
  logic [3:0]  wstrb_first;
  logic [3:0]  wstrb_at_rdy;
  logic [31:0] saddr_first;
  logic [31:0] swdata_first;
  logic        pulse_seen;

  always #5 clk = ~clk;

  assign s_rdata = {D3, D2, D1, D0};
  assign s_ready = (s_req & {NS{acc_cnt == ready_at}}) | stray;

  // Counts consecutive cycles a slave select has been held.
  always @(posedge clk) acc_cnt <= (s_req != '0) ? acc_cnt + 1 : 0;

  mmio_interconnect #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .DEC_BITS   (DB),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .err_addr (err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One master access; master inputs are scrambled right after accept.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int rdy_at, input logic [NS-1:0] stray_in);
    ready_at = rdy_at;
    stray    = stray_in;
    @(negedge clk);
    m_req   = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    obs_lat  = 0;
    obs_done = 1'b0;
    obs_req  = '0;
    while (!obs_done && obs_lat < 50) begin
      @(negedge clk);
      obs_lat++;
      if (obs_lat == 1) begin
        saddr_first  = s_addr;
        swdata_first = s_wdata;
        wstrb_first  = s_wstrb;
        m_addr  = ~addr;
        m_wdata = ~wdata;
      end
      obs_req = obs_req | s_req;
      if (m_ready) begin
        obs_done     = 1'b1;
        obs_rdata    = m_rdata;
        obs_err      = m_err;
        req_at_rdy   = s_req;
        wstrb_at_rdy = s_wstrb;
      end
    end
    m_req    = 1'b0;
    m_wstrb  = '0;
    stray    = '0;
    ready_at = 99;
    chk({tag, "_done"}, 64'(obs_done), 64'd1);
  endtask

  initial begin
    rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_s_wstrb", 64'(s_wstrb), 64'd0);
    rst = 1'b0;

    // Read slave 3, ready immediately.
    do_access("rd3", 32'h5000_0040, 32'h0, 4'h0, 0, '0);
    chk("rd3_lat", 64'(obs_lat), 64'd2);
    chk("rd3_rdata", 64'(obs_rdata), 64'(D3));
    chk("rd3_err", 64'(obs_err), 64'd0);
    chk("rd3_sreq", 64'(obs_req), 64'h8);
    chk("rd3_saddr", 64'(saddr_first), 64'h5000_0040);

    // Write slave 0 with partial strobes.
    do_access("wr0", 32'h0000_0010, 32'h1234_5678, 4'b0011, 0, '0);
    chk("wr0_lat", 64'(obs_lat), 64'd2);
    chk("wr0_sreq", 64'(obs_req), 64'h1);
    chk("wr0_wstrb_acc", 64'(wstrb_first), 64'h3);
    chk("wr0_wdata", 64'(swdata_first), 64'h1234_5678);
    chk("wr0_wstrb_resp", 64'(wstrb_at_rdy), 64'h0);
    chk("wr0_err", 64'(obs_err), 64'd0);

    // Unmapped region.
    do_access("unm", 32'h2000_0ABC, 32'h0, 4'h0, 0, '0);
    chk("unm_lat", 64'(obs_lat), 64'd1);
    chk("unm_err", 64'(obs_err), 64'd1);
    chk("unm_rdata", 64'(obs_rdata), 64'd0);
    chk("unm_sreq", 64'(obs_req), 64'h0);
    chk("unm_err_addr", 64'(err_addr), 64'h2000_0ABC);

    // Timeout; stray ready on unselected slave 3 must be ignored.
    do_access("tmo", 32'h0000_0100, 32'h0, 4'h0, 99, 4'b1000);
    chk("tmo_lat", 64'(obs_lat), 64'd5);
    chk("tmo_err", 64'(obs_err), 64'd1);
    chk("tmo_rdata", 64'(obs_rdata), 64'd0);
    chk("tmo_sreq_resp", 64'(req_at_rdy), 64'h0);
    chk("tmo_err_addr", 64'(err_addr), 64'h0000_0100);

    // Ready coincides with the timeout cycle: ready wins.
    do_access("rdy4", 32'h0000_0200, 32'h0, 4'h0, 3, '0);
    chk("rdy4_lat", 64'(obs_lat), 64'd5);
    chk("rdy4_err", 64'(obs_err), 64'd0);
    chk("rdy4_rdata", 64'(obs_rdata), 64'(D0));
    chk("rdy4_err_addr", 64'(err_addr), 64'h0000_0100);

    // Overlap: 0xC matches slaves 1 and 2.
    do_access("ovl", 32'hC000_0004, 32'h0, 4'h0, 0, '0);
    chk("ovl_sreq", 64'(obs_req), 64'h2);
    chk("ovl_rdata", 64'(obs_rdata), 64'(D1));

    // Reset during ACCESS.
    ready_at = 99;
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h0000_0300; m_wdata = 32'h5555_AAAA; m_wstrb = 4'hF;
    @(negedge clk);
    chk("mid_sreq", 64'(s_req), 64'h1);
    chk("mid_wstrb", 64'(s_wstrb), 64'hF);
    rst = 1'b1; m_req = 1'b0; m_wstrb = '0;
    @(negedge clk);
    chk("mrst_s_req", 64'(s_req), 64'd0);
    chk("mrst_s_wstrb", 64'(s_wstrb), 64'd0);
    chk("mrst_m_ready", 64'(m_ready), 64'd0);
    chk("mrst_m_err", 64'(m_err), 64'd0);
    chk("mrst_m_rdata", 64'(m_rdata), 64'd0);
    chk("mrst_err_addr", 64'(err_addr), 64'd0);
    rst = 1'b0;
    pulse_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      pulse_seen = pulse_seen | m_ready;
    end
    chk("mrst_no_pulse", 64'(pulse_seen), 64'd0);

    do_access("post", 32'h5000_0000, 32'h0, 4'h0, 0, '0);
    chk("post_lat", 64'(obs_lat), 64'd2);
    chk("post_rdata", 64'(obs_rdata), 64'(D3));
    chk("post_err", 64'(obs_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
